// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction fetch against load/store and moves one
// byte per cycle over the shared memory bus, assembling little-endian read data.
module mem_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  // Cycles from address driven to byte valid on mem_din
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr,
  input  logic                  if_req_in,
  input  logic [ADDR_WIDTH-1:0] if_addr_in,
  input  logic                  if_flush_in,
  output logic                  if_done_out,
  output logic [31:0]           if_data_out,
  input  logic                  lsu_req_in,
  input  logic                  lsu_wr_in,
  input  logic [1:0]            lsu_size_in,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_in,
  input  logic [31:0]           lsu_data_in,
  output logic                  lsu_done_out,
  output logic [31:0]           lsu_data_out
);

  // Counter must reach N + RD_LAT - 1 for a 4-byte read
  localparam int unsigned CntW = $clog2(RD_LAT + 5);
  typedef logic [CntW-1:0] cnt_t;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StDone
  } state_e;

  state_e                r_state, w_state_nxt;
  cnt_t                  r_cnt, w_cnt_nxt;
  cnt_t                  r_len, w_len_nxt;
  logic [ADDR_WIDTH-1:0] r_base, w_base_nxt;
  logic                  r_owner_lsu, w_owner_lsu_nxt;
  logic [31:0]           r_wdata, w_wdata_nxt;
  // Set when a read was paused; the bus bytes seen so far are no longer trustworthy
  logic                  r_restart, w_restart_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [7:0]            r_mem_dout, w_mem_dout_nxt;
  logic                  r_mem_wr, w_mem_wr_nxt;
  logic [31:0]           r_if_data, w_if_data_nxt;
  logic [31:0]           r_lsu_data, w_lsu_data_nxt;

  cnt_t                  w_lsu_len;
  cnt_t                  w_cnt_inc;
  cnt_t                  w_last_rd;
  logic [1:0]            w_byte_sel;
  logic [ADDR_WIDTH-1:0] w_addr_inc;

  // Decode the load/store access size into a byte count
  always_comb begin
    w_lsu_len = cnt_t'(4);
    unique case (lsu_size_in)
      2'b00:   w_lsu_len = cnt_t'(1);
      2'b01:   w_lsu_len = cnt_t'(2);
      default: w_lsu_len = cnt_t'(4);
    endcase
  end

  assign w_cnt_inc  = r_cnt + cnt_t'(1);
  assign w_last_rd  = r_len + cnt_t'(RD_LAT - 1);
  assign w_byte_sel = 2'(r_cnt - cnt_t'(RD_LAT));
  assign w_addr_inc = r_base + {{(ADDR_WIDTH - CntW){1'b0}}, w_cnt_inc};

  // Next-state and next-output logic for the bus sequencer
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_len_nxt       = r_len;
    w_base_nxt      = r_base;
    w_owner_lsu_nxt = r_owner_lsu;
    w_wdata_nxt     = r_wdata;
    w_restart_nxt   = r_restart;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_dout_nxt  = r_mem_dout;
    w_mem_wr_nxt    = r_mem_wr;
    w_if_data_nxt   = r_if_data;
    w_lsu_data_nxt  = r_lsu_data;

    if (!rdy_in) begin
      // Host owns the bus: everything holds, a paused read must start over
      if (r_state == StRead) begin
        w_restart_nxt = 1'b1;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          w_mem_wr_nxt = 1'b0;
          if (lsu_req_in) begin
            w_owner_lsu_nxt = 1'b1;
            w_base_nxt      = lsu_addr_in;
            w_len_nxt       = w_lsu_len;
            w_wdata_nxt     = lsu_data_in;
            w_cnt_nxt       = '0;
            w_restart_nxt   = 1'b0;
            w_mem_addr_nxt  = lsu_addr_in;
            if (lsu_wr_in) begin
              w_state_nxt    = StWrite;
              w_mem_wr_nxt   = 1'b1;
              w_mem_dout_nxt = lsu_data_in[7:0];
            end else begin
              w_state_nxt    = StRead;
              w_lsu_data_nxt = '0;
            end
          end else if (if_req_in && !if_flush_in) begin
            w_owner_lsu_nxt = 1'b0;
            w_base_nxt      = if_addr_in;
            w_len_nxt       = cnt_t'(4);
            w_cnt_nxt       = '0;
            w_restart_nxt   = 1'b0;
            w_mem_addr_nxt  = if_addr_in;
            w_state_nxt     = StRead;
            w_if_data_nxt   = '0;
          end
        end

        StRead: begin
          w_mem_wr_nxt = 1'b0;
          if (!r_owner_lsu && if_flush_in) begin
            w_state_nxt   = StIdle;
            w_cnt_nxt     = '0;
            w_restart_nxt = 1'b0;
          end else if (r_restart) begin
            // Re-issue from the base address and drop any partial data
            w_cnt_nxt      = '0;
            w_restart_nxt  = 1'b0;
            w_mem_addr_nxt = r_base;
            if (r_owner_lsu) begin
              w_lsu_data_nxt = '0;
            end else begin
              w_if_data_nxt = '0;
            end
          end else begin
            if (r_cnt >= cnt_t'(RD_LAT)) begin
              if (r_owner_lsu) begin
                w_lsu_data_nxt[{w_byte_sel, 3'b000} +: 8] = mem_din;
              end else begin
                w_if_data_nxt[{w_byte_sel, 3'b000} +: 8] = mem_din;
              end
            end
            if (r_cnt == w_last_rd) begin
              w_state_nxt = StDone;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = w_cnt_inc;
              if (w_cnt_inc < r_len) begin
                w_mem_addr_nxt = w_addr_inc;
              end
            end
          end
        end

        StWrite: begin
          if (r_cnt == r_len - cnt_t'(1)) begin
            w_state_nxt  = StDone;
            w_cnt_nxt    = '0;
            w_mem_wr_nxt = 1'b0;
          end else begin
            w_cnt_nxt      = w_cnt_inc;
            w_mem_addr_nxt = w_addr_inc;
            w_mem_dout_nxt = r_wdata[{w_cnt_inc[1:0], 3'b000} +: 8];
            w_mem_wr_nxt   = 1'b1;
          end
        end

        StDone: begin
          w_mem_wr_nxt = 1'b0;
          w_state_nxt  = StIdle;
        end

        default: begin
          w_state_nxt  = StIdle;
          w_mem_wr_nxt = 1'b0;
        end
      endcase
    end
  end

  // State and registered bus outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_len       <= '0;
      r_base      <= '0;
      r_owner_lsu <= 1'b0;
      r_wdata     <= '0;
      r_restart   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_dout  <= '0;
      r_mem_wr    <= 1'b0;
      r_if_data   <= '0;
      r_lsu_data  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_len       <= w_len_nxt;
      r_base      <= w_base_nxt;
      r_owner_lsu <= w_owner_lsu_nxt;
      r_wdata     <= w_wdata_nxt;
      r_restart   <= w_restart_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_dout  <= w_mem_dout_nxt;
      r_mem_wr    <= w_mem_wr_nxt;
      r_if_data   <= w_if_data_nxt;
      r_lsu_data  <= w_lsu_data_nxt;
    end
  end

  assign mem_addr     = r_mem_addr;
  assign mem_dout     = r_mem_dout;
  // Never write while the host owns the bus
  assign mem_wr       = r_mem_wr & rdy_in;
  assign if_data_out  = r_if_data;
  assign lsu_data_out = r_lsu_data;
  // Done pulses only in the DONE cycle that actually advances; a flush kills a fetch completion
  assign if_done_out  = (r_state == StDone) && !r_owner_lsu && rdy_in && !if_flush_in;
  assign lsu_done_out = (r_state == StDone) && r_owner_lsu && rdy_in;

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-serial memory controller inside the CPU, directly upstream of the top-level memory/IO bus mux.
- Arbitrates between instruction fetch (4-byte reads) and load/store (1/2/4-byte reads or writes).
- Drives one byte per cycle onto mem_addr/mem_dout/mem_wr and assembles read bytes, little-endian, from mem_din.
- Pauses on rdy_in low, while the host interface owns the bus.

Parameters:
ADDR_WIDTH, 32, width of mem_addr and request addresses
RD_LAT, 1, cycles from address driven to byte valid on mem_din (RAM and IO are both 1)

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous active-low reset
rdy_in  input  1  1 = bus owned by CPU; 0 = pause
mem_din  input  8  read byte from bus
mem_dout  output  8  write byte to bus
mem_addr  output  32  byte address
mem_wr  output  1  1 = write, 0 = read
if_req_in  input  1  fetch request (level, held until if_done_out)
if_addr_in  input  32  fetch address
if_flush_in  input  1  abort in-flight fetch
if_done_out  output  1  one-cycle pulse: if_data_out valid
if_data_out  output  32  fetched word
lsu_req_in  input  1  load/store request (level, held until lsu_done_out)
lsu_wr_in  input  1  1 = store
lsu_size_in  input  2  00 byte, 01 half, 10/11 word
lsu_addr_in  input  32  access address
lsu_data_in  input  32  store data (low bytes used)
lsu_done_out  output  1  one-cycle pulse: access complete
lsu_data_out  output  32  load data, zero-extended

Behaviour:
- Reset (async, rst_n_in=0):
  - State IDLE.
  - mem_addr, mem_dout, mem_wr, if_done_out, lsu_done_out, if_data_out, lsu_data_out all 0.
  - Byte counter 0.
- States: IDLE, READ, WRITE, DONE.
- IDLE arbitration at the clock edge:
  - lsu_req_in wins over if_req_in.
  - Latch base address, byte count N (1/2/4; fetch always 4), owner, and store data.
  - Go to WRITE if owner is LSU and lsu_wr_in=1; otherwise go to READ.
  - In IDLE: mem_wr=0, mem_addr holds its last value.
- READ, counter c = 0..N:
  - Drive mem_addr = base+c while c<N (32-bit wrap), mem_wr=0.
  - On each edge with c>=1, capture mem_din into byte c-1 of the owner's data register.
  - After the edge capturing byte N-1, go to DONE.
  - Word read: request sampled at edge E0; done pulse high in the cycle after E5.
- WRITE:
  - Cycle c drives mem_addr = base+c, mem_dout = store byte c, mem_wr=1.
  - After byte N-1, go to DONE.
  - Word store: 4 bus cycles plus 1 DONE cycle.
- DONE:
  - Pulse the owner's done output for exactly 1 cycle; mem_wr=0.
  - Data register stable; unused upper bytes are 0.
  - No request is granted in DONE; return to IDLE. Requester must drop its req in the DONE cycle.
- rdy_in=0:
  - State, counter and outputs hold; mem_wr forced 0; no capture on that edge.
  - READ in progress: on resumption, counter restarts at 0 and already-captured bytes are discarded (the bus data was corrupted by the host).
  - WRITE in progress: resumes at the current byte; earlier bytes stay committed.
- if_flush_in=1:
  - If owner is fetch in READ: go to IDLE at the next edge; no if_done_out.
  - An if_req_in in the same cycle is ignored.
  - LSU transactions are never aborted by flush.
- Flush during DONE for fetch: if_done_out is suppressed.
- Address wrap: 0xFFFFFFFF+1 = 0x00000000.
- IO region (addr[17:16]=11) uses identical timing; no special casing.

Test Plan:
- RAM[0x1000..0x1003] = 13 05 00 00; fetch 0x1000 -> mem_addr 0x1000..0x1003 on consecutive cycles; if_done_out 5 cycles after request edge; if_data_out = 0x00000513.
- Store half 0xBEEF to 0x2002 -> mem_wr=1 for 2 cycles, (0x2002,EF) then (0x2003,BE); lsu_done_out 1 cycle later; mem_wr=0.
- if_req_in and lsu_req_in (load byte 0x80 at 0x3000) raised together -> LSU served first, lsu_data_out = 0x00000080; fetch starts after DONE+IDLE.
- Fetch in flight, if_flush_in pulsed after 2 bytes -> IDLE next edge; no if_done_out; new fetch at 0x2000 returns the correct word.
- rdy_in low 3 cycles mid word-load -> outputs frozen, mem_wr=0; on resume, read restarts at base and returns the correct 0xDEADBEEF.
- rst_n_in low mid word-store after 2 bytes -> all outputs 0 immediately; only those 2 bytes modified in RAM.
